// File: rtl/sync_debounce_n.sv
// Multi-channel input synchronizer and debouncer with registered rise/fall pulses.
// Define SYNC_DEBOUNCE_SIM_FAST_EN to shorten the debounce threshold to 2 for simulation only.
module sync_debounce_n #(
  parameter int               WIDTH         = 4,
  parameter int               SYNC_STAGES   = 2,
  parameter int               STABLE_CYCLES = 16,
  parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] busy
);

`ifdef SYNC_DEBOUNCE_SIM_FAST_EN
  localparam int THRESH = 2;
`else
  localparam int THRESH = STABLE_CYCLES;
`endif

  localparam int              CNT_W    = (THRESH > 1) ? $clog2(THRESH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(THRESH - 1);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [CNT_W-1:0] r_cnt  [WIDTH];
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic [WIDTH-1:0] w_s;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= RESET_VAL;
    end else begin
      r_sync[0] <= d;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // Each channel counts consecutive cycles of disagreement; any agreement restarts it.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_q    <= RESET_VAL;
      r_rise <= '0;
      r_fall <= '0;
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        r_rise[i] <= 1'b0;
        r_fall[i] <= 1'b0;
        if (w_s[i] == r_q[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_q[i]    <= w_s[i];
          r_cnt[i]  <= '0;
          r_rise[i] <= w_s[i];
          r_fall[i] <= ~w_s[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < WIDTH; i++) busy[i] = (r_cnt[i] != '0);
  end

  assign q    = r_q;
  assign rise = r_rise;
  assign fall = r_fall;

endmodule

// File: tb/tb_sync_debounce_n.sv
// Bench for sync_debounce_n: exact-latency sequences around reset and steps, plus a vector table.
// Build with SYNC_DEBOUNCE_SIM_FAST_EN defined to exercise the shortened threshold.
module tb_sync_debounce_n;
  localparam int SYNC   = 2;
  localparam int STABLE = 8;
`ifdef SYNC_DEBOUNCE_SIM_FAST_EN
  localparam int THR = 2;
`else
  localparam int THR = STABLE;
`endif
  localparam int LAT   = SYNC + THR;
  localparam int SHORT = (THR > 1) ? THR - 1 : 1;
  localparam int LONG  = LAT + 4;
  localparam int PRE   = (LAT >= 10) ? 6 : LAT - 2;

  logic       Clk   = 1'b0;
  logic       Reset = 1'b1;
  logic [3:0] d     = 4'h0;
  logic [3:0] q, rise, fall, busy;

  sync_debounce_n #(
    .WIDTH(4), .SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE), .RESET_VAL(4'h0)
  ) dut (
    .Clk(Clk), .Reset(Reset), .d(d), .q(q), .rise(rise), .fall(fall), .busy(busy)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] d;
    int         hold;
    logic [3:0] q;
    logic [3:0] rise;
    logic [3:0] fall;
    bit         chk_busy;
  } vec_t;

  typedef struct {
    logic [3:0] q;
    logic [3:0] rise;
    logic [3:0] fall;
    bit         chk_busy;
  } exp_t;

  vec_t vecs[10];
  exp_t sb[$];

  initial begin
    exp_t       e;
    logic [3:0] seen_r, seen_f, multi, both;

    vecs[0] = '{4'b0000, LONG,  4'b0000, 4'b0000, 4'b1111, 1'b1};
    vecs[1] = '{4'b0001, SHORT, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[2] = '{4'b0000, LONG,  4'b0000, 4'b0000, 4'b0000, 1'b1};
    vecs[3] = '{4'b0010, LONG,  4'b0010, 4'b0010, 4'b0000, 1'b1};
    vecs[4] = '{4'b1010, LONG,  4'b1010, 4'b1000, 4'b0000, 1'b1};
    vecs[5] = '{4'b0110, LONG,  4'b0110, 4'b0100, 4'b1000, 1'b1};
    vecs[6] = '{4'b0111, SHORT, 4'b0110, 4'b0000, 4'b0000, 1'b0};
    vecs[7] = '{4'b0110, LONG,  4'b0110, 4'b0000, 4'b0000, 1'b1};
    vecs[8] = '{4'b1001, LONG,  4'b1001, 4'b1001, 4'b0110, 1'b1};
    vecs[9] = '{4'b0000, LONG,  4'b0000, 4'b0000, 4'b1001, 1'b1};

    // Reset held with all inputs high, then exact release latency
    Reset = 1'b1;
    d     = 4'hF;
    repeat (3) @(negedge Clk);
    chk("rst_q", q, 4'h0);
    chk("rst_rise", rise, 4'h0);
    chk("rst_fall", fall, 4'h0);
    chk("rst_busy", busy, 4'h0);
    Reset = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(posedge Clk);
      @(negedge Clk);
      chk($sformatf("rel_q_e%0d", k), q, (k >= LAT) ? 4'hF : 4'h0);
      chk($sformatf("rel_rise_e%0d", k), rise, (k == LAT) ? 4'hF : 4'h0);
      chk($sformatf("rel_fall_e%0d", k), fall, 4'h0);
    end

    // Vector table through the scoreboard
    for (int i = 0; i < 10; i++) begin
      d = vecs[i].d;
      sb.push_back('{vecs[i].q, vecs[i].rise, vecs[i].fall, vecs[i].chk_busy});
      seen_r = '0; seen_f = '0; multi = '0; both = '0;
      repeat (vecs[i].hold) begin
        @(posedge Clk);
        @(negedge Clk);
        multi  = multi | (seen_r & rise) | (seen_f & fall);
        seen_r = seen_r | rise;
        seen_f = seen_f | fall;
        both   = both | (rise & fall);
      end
      e = sb.pop_front();
      chk($sformatf("vec%0d_q", i), q, e.q);
      chk($sformatf("vec%0d_rise", i), seen_r, e.rise);
      chk($sformatf("vec%0d_fall", i), seen_f, e.fall);
      chk($sformatf("vec%0d_pulse_width", i), multi, 4'h0);
      chk($sformatf("vec%0d_rise_and_fall", i), both, 4'h0);
      if (e.chk_busy) chk($sformatf("vec%0d_busy", i), busy, 4'h0);
    end

    // Clean step on channel 1 with per-edge latency and busy window
    d = 4'b0010;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(posedge Clk);
      @(negedge Clk);
      chk($sformatf("step_q_e%0d", k), q, (k >= LAT) ? 4'b0010 : 4'b0000);
      chk($sformatf("step_rise_e%0d", k), rise, (k == LAT) ? 4'b0010 : 4'b0000);
      chk($sformatf("step_busy_e%0d", k), busy,
          (k >= SYNC + 1 && k <= LAT - 1) ? 4'b0010 : 4'b0000);
    end
    d = 4'b0000;
    repeat (LONG) @(negedge Clk);
    chk("step_return_q", q, 4'b0000);

    // Reset in the middle of a count discards it; count restarts after release
    d = 4'b0001;
    for (int k = 1; k <= PRE; k++) begin
      @(posedge Clk);
      @(negedge Clk);
      chk($sformatf("mc_q_e%0d", k), q, 4'b0000);
      chk($sformatf("mc_rise_e%0d", k), rise, 4'b0000);
    end
    chk("mc_busy_pre", busy, (PRE >= SYNC + 1) ? 4'b0001 : 4'b0000);
    Reset = 1'b1;
    #1;
    chk("mc_rst_q", q, 4'b0000);
    chk("mc_rst_busy", busy, 4'b0000);
    chk("mc_rst_rise", rise, 4'b0000);
    chk("mc_rst_fall", fall, 4'b0000);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(posedge Clk);
      @(negedge Clk);
      chk($sformatf("mc_rel_q_e%0d", k), q, (k >= LAT) ? 4'b0001 : 4'b0000);
      chk($sformatf("mc_rel_rise_e%0d", k), rise, (k == LAT) ? 4'b0001 : 4'b0000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
